fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register of the RV32 core.
//  - Owns the PC and handshakes with instruction memory (variable latency).
//  - Presents the fetched instruction to decode; opcode_o drives the main control unit's opcode_i.
//  - Takes stall from decode and branch redirects from EX.
// PARAMETERS
//  XLEN      32             address/PC width
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INSN  32'h0000_0013  bubble instruction (addi x0,x0,0)
// PORTS
//  clk_i            in   1     clock, all state on rising edge
//  rst_i            in   1     synchronous reset, active-high
//  imem_req_o       out  1     fetch request; addr held stable until imem_ack_i
//  imem_addr_o      out  XLEN  fetch address (word aligned)
//  imem_ack_i       in   1     imem_rdata_i valid this cycle (>=1 cycle after req)
//  imem_rdata_i     in   32    fetched instruction
//  stall_i          in   1     decode cannot accept; hold IF/ID register
//  branch_taken_i   in   1     redirect from EX (branch_o & zero)
//  branch_target_i  in   XLEN  redirect address; bits[1:0] forced to 0
//  if_valid_o       out  1     IF/ID register holds a real instruction
//  if_pc_o          out  XLEN  PC of if_instr_o
//  if_instr_o       out  32    IF/ID instruction
//  opcode_o         out  7     if_instr_o[6:0]
// BEHAVIOUR
//  Reset (rst_i=1 at edge; overrides everything):
//   state=BOOT, pc=RESET_PC, imem_req_o=0, if_valid_o=0,
//   if_pc_o=0, if_instr_o=NOP_INSN, opcode_o=7'b0010011, skid empty.
//  FSM (registered, 4 states):
//   BOOT : req=0; next FETCH (one idle cycle after reset).
//   FETCH: req=1, addr=pc.
//    - ack & !stall & !branch: load IF/ID {1,pc,rdata}, pc+=4, stay FETCH.
//    - ack & stall & !branch : rdata/pc into skid, pc+=4, go HOLD.
//    - no ack & branch       : pc=target, go KILL (request stays outstanding).
//    - ack & branch          : drop rdata, pc=target, stay FETCH.
//   HOLD : req=0; when !stall, move skid to IF/ID, go FETCH.
//          On branch, drop skid, pc=target, go FETCH.
//   KILL : req=1 with old addr; on ack discard rdata, go FETCH (new pc).
//          Another branch while in KILL updates pc to the newest target.
//  IF/ID register:
//   - stall_i=1 & !branch: all if_* hold.
//   - branch_taken_i=1: next cycle if_valid_o=0, if_instr_o=NOP_INSN (flush).
//     Branch has priority over stall.
//   - !stall & no instruction delivered: bubble (valid=0, instr=NOP_INSN, pc holds).
//  Timing and arithmetic:
//   - Fetch latency: ack cycle N -> if_* valid at cycle N+1.
//   - Zero-wait memory (ack each cycle) sustains 1 instr/cycle.
//   - pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
//   - imem_addr_o never changes while req=1 and ack not yet seen.
//  Reset mid-request abandons it; any late ack after reset is ignored
//  while in BOOT.
// TESTING
//  1 Reset, 0-wait mem returning addr-tagged words -> first if_valid_o on cycle 3,
//    if_pc_o 0,4,8,... consecutive; opcode_o = rdata[6:0].
//  2 Mem ack latency 3 cycles -> req/addr stable across wait;
//    one instr per 4 cycles, bubbles (NOP, valid=0) between.
//  3 stall_i high 5 cycles during ack at pc=0x10 -> if_* frozen,
//    0x10 delivered from skid on release, then 0x14; none lost or duplicated.
//  4 branch to 0x100 during outstanding req at 0x20 (latency 2)
//    -> 0x20 data discarded, next issued addr 0x100, IF/ID flushed for one cycle.
//  5 branch & stall same cycle -> flush wins: if_valid_o=0, next fetch 0x100.
//  6 RESET_PC=32'hFFFF_FFF8 -> pc sequence FFF8, FFFC, 0000;
//    rst_i pulsed mid-wait -> back to BOOT, late ack ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, handshakes with variable-latency imem, absorbs decode stalls and EX redirects.
module fetch_stage #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0,
    parameter logic [31:0]         NOP_INSN = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    output logic [6:0]      opcode_o
);

    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_KILL  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic [ILEN-1:0]   skid_instr_q, skid_instr_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [ILEN-1:0]   if_instr_q, if_instr_d;

    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_inc;

    assign target = {branch_target_i[XLEN-1:2], 2'b00};
    assign pc_inc = pc_q + XLEN'(4);

    // Next-state, PC, skid and IF/ID update
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        // Flush on redirect, bubble when decode consumed and nothing new arrives
        if (branch_taken_i || !stall_i) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSN;
        end

        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (branch_taken_i) begin
                    pc_d    = target;
                    state_d = imem_ack_i ? ST_FETCH : ST_KILL;
                end else if (imem_ack_i) begin
                    pc_d = pc_inc;
                    if (stall_i) begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata_i;
                        state_d      = ST_HOLD;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata_i;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken_i) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (!stall_i) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = skid_pc_q;
                    if_instr_d = skid_instr_q;
                    state_d    = ST_FETCH;
                end
            end
            ST_KILL: begin
                if (branch_taken_i) begin
                    pc_d = target;
                end
                if (imem_ack_i) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // KILL keeps presenting the abandoned address until its ack drains
        req_d  = (state_d == ST_FETCH) || (state_d == ST_KILL);
        addr_d = (state_d == ST_FETCH) ? pc_d : addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSN;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSN;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign if_valid_o  = if_valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;
    assign opcode_o    = if_instr_q[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable imem model and a scoreboard of expected deliveries.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, branch;
    logic [31:0] target;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic [6:0]  opcode;

    logic        rst2, req2, valid2, zero2;
    logic [31:0] addr2, pc2, instr2, target2;
    logic [6:0]  opcode2;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat = 0;
    logic        mem_force = 1'b0;
    int          cnt = 0;
    int          cyc = 0;
    int          last_cyc = -1;
    int          exp_gap = 0;
    logic        sb_en = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_e, sb_t;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'hA5C3_0000;
    endfunction

    fetch_stage dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
        .stall_i(stall), .branch_taken_i(branch), .branch_target_i(target),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr), .opcode_o(opcode)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk_i(clk), .rst_i(rst2),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ack_i(req2), .imem_rdata_i(tag(addr2)),
        .stall_i(zero2), .branch_taken_i(zero2), .branch_target_i(target2),
        .if_valid_o(valid2), .if_pc_o(pc2), .if_instr_o(instr2), .opcode_o(opcode2)
    );

    // imem model: acks after `lat` waiting cycles; mem_force injects a stray ack
    assign imem_ack   = mem_force | (imem_req && (cnt >= lat));
    assign imem_rdata = mem_force ? 32'hDEAD_BEEF : tag(imem_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || !imem_req || imem_ack) cnt <= 0;
        else                              cnt <= cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Decode consumes when valid, not stalled and not being flushed
    always @(negedge clk) begin
        if (sb_en && if_valid && !stall && !branch && exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            sb_t = tag(sb_e);
            check("sb_pc", if_pc, sb_e);
            check("sb_instr", if_instr, sb_t);
            check("sb_opcode", 32'(opcode), 32'(sb_t[6:0]));
            if (exp_gap != 0 && last_cyc >= 0) check("sb_gap", 32'(cyc - last_cyc), 32'(exp_gap));
            last_cyc = cyc;
        end
        if (sb_en && !if_valid) check("bubble_nop", if_instr, NOP);
        if (prev_pend && imem_req) check("addr_stable", imem_addr, prev_addr);
        prev_pend = imem_req && !imem_ack && !rst;
        prev_addr = imem_addr;
    end

    task automatic reset_dut();
        rst = 1'b1; sb_en = 1'b0; stall = 1'b0; branch = 1'b0; mem_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
    endtask

    task automatic start_sb(input int gap);
        exp_gap = gap; last_cyc = -1; sb_en = 1'b1;
    endtask

    task automatic wait_empty(input string name);
        logic ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
        sb_en = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_addr(input logic [31:0] a);
        logic ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (imem_req && imem_addr == a) begin ok = 1'b1; break; end
        end
        check("wait_addr", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [31:0] got2[3];
        int          n2;
        logic        moved;
        rst2 = 1'b1; zero2 = 1'b0; target2 = '0; target = '0;

        // 1: reset values, zero-wait streaming, first valid on cycle 3
        lat = 0;
        reset_dut();
        rst = 1'b0;
        push_seq(32'h0, 8);
        start_sb(1);
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_instr", if_instr, NOP);
        check("rst_opcode", 32'(opcode), 32'h13);
        @(negedge clk);
        check("c2_req", 32'(imem_req), 32'd1);
        check("c2_addr", imem_addr, 32'h0);
        check("c2_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        check("c3_valid", 32'(if_valid), 32'd1);
        wait_empty("t1_drain");

        // 2: 3-cycle latency, one instruction every 4 cycles with NOP bubbles
        lat = 3;
        reset_dut(); rst = 1'b0;
        push_seq(32'h0, 6);
        start_sb(4);
        wait_empty("t2_drain");

        // 3: 5-cycle stall while 0x10 is acked; skid replays it once
        lat = 0;
        reset_dut(); rst = 1'b0;
        push_seq(32'h0, 8);
        start_sb(0);
        wait_addr(32'h10);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc", if_pc, 32'h0C);
            check("stall_instr", if_instr, tag(32'h0C));
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_empty("t3_drain");

        // 4: redirect to 0x100 while 0x20 is outstanding (latency 2)
        lat = 2;
        reset_dut(); rst = 1'b0;
        push_seq(32'h0, 7);
        push_seq(32'h100, 3);
        start_sb(0);
        wait_addr(32'h20);
        branch = 1'b1; target = 32'h0000_0100;
        @(posedge clk); #1;
        branch = 1'b0;
        @(negedge clk);
        check("t4_flush_valid", 32'(if_valid), 32'd0);
        check("t4_flush_instr", if_instr, NOP);
        check("t4_kill_addr", imem_addr, 32'h20);
        moved = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr != 32'h20) begin moved = 1'b1; break; end
            @(negedge clk);
        end
        check("t4_moved", 32'(moved), 32'd1);
        check("t4_new_addr", imem_addr, 32'h100);
        wait_empty("t4_drain");

        // 5: branch and stall together, flush wins; unaligned target bits dropped
        lat = 0;
        reset_dut(); rst = 1'b0;
        push_seq(32'h0, 3);
        push_seq(32'h100, 3);
        start_sb(0);
        wait_addr(32'h10);
        stall = 1'b1; branch = 1'b1; target = 32'h0000_0102;
        @(posedge clk); #1;
        stall = 1'b0; branch = 1'b0;
        @(negedge clk);
        check("t5_flush_valid", 32'(if_valid), 32'd0);
        check("t5_flush_instr", if_instr, NOP);
        check("t5_addr", imem_addr, 32'h100);
        wait_empty("t5_drain");

        // 6a: reset mid-wait, stray ack during BOOT ignored
        lat = 3;
        reset_dut(); rst = 1'b0;
        wait_addr(32'h8);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_force = 1'b1;
        @(negedge clk);
        check("t6_boot_req", 32'(imem_req), 32'd0);
        check("t6_boot_valid", 32'(if_valid), 32'd0);
        @(posedge clk); #1;
        mem_force = 1'b0;
        @(negedge clk);
        check("t6_late_valid", 32'(if_valid), 32'd0);
        check("t6_late_instr", if_instr, NOP);
        check("t6_restart_addr", imem_addr, 32'h0);
        push_seq(32'h0, 3);
        start_sb(4);
        wait_empty("t6_drain");

        // 6b: PC wrap from a high RESET_PC
        @(posedge clk); #1;
        rst2 = 1'b0;
        n2 = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid2 && n2 < 3) begin
                check("t6_wrap_instr", instr2, tag(pc2));
                got2[n2] = pc2;
                n2++;
            end
        end
        check("t6_wrap_count", 32'(n2), 32'd3);
        check("t6_wrap_pc0", got2[0], 32'hFFFF_FFF8);
        check("t6_wrap_pc1", got2[1], 32'hFFFF_FFFC);
        check("t6_wrap_pc2", got2[2], 32'h0000_0000);
        rst2 = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
